// File: rtl/pipelined_mac_unit.sv
// Pipelined multiply-accumulate unit.
// Stage 1 registers the operands, stage 2 registers the Wallace-tree product,
// stage 3 folds the product into a wide accumulator with an optional clamp and
// a sticky overflow flag. A beat is accepted on every rising edge with
// in_valid high. The edge that samples the beat counts as the first of three,
// and the result shows on out_valid/acc_out after the third.
module pipelined_mac_unit #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 clr,
    input  logic                 signed_mode,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 overflow
);

    localparam int PW     = 2 * WIDTH;
    localparam int NPP    = PW;
    localparam int IW     = $clog2(NPP + 1);
    localparam int NSLOT  = 1 << IW;
    localparam int LEVELS = 2 * IW;

    // The accumulator must hold at least one full-width product.
    generate
        if (ACC_WIDTH < PW) begin : g_badAccWidth
            $error("pipelined_mac_unit: ACC_WIDTH must be at least 2*WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_clr1;
    logic                 r_mode1;
    logic                 r_v1;
    logic [PW-1:0]        r_product;
    logic                 r_clr2;
    logic                 r_mode2;
    logic                 r_v2;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;
    logic                 r_outValid;

    logic [PW-1:0]        w_aExt;
    logic [PW-1:0]        w_bExt;
    logic [PW-1:0]        w_product;
    logic [ACC_WIDTH-1:0] w_extProd;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_ovf;
    logic [ACC_WIDTH-1:0] w_satVal;
    logic [ACC_WIDTH-1:0] w_accNext;

    // Stage 1: capture the operands and per-beat controls of accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_clr1  <= 1'b0;
            r_mode1 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_a     <= a;
                r_b     <= b;
                r_clr1  <= clr;
                r_mode1 <= signed_mode;
            end
        end
    end

    // Wallace tree: operands are widened to 2*WIDTH bits (sign- or zero-
    // extended by mode) so every partial product is correct modulo 2^(2*WIDTH);
    // rows are then reduced three-to-two with full adders until two remain.
    always_comb begin : p_wallace
        logic [PW-1:0] w_rows [NSLOT];
        logic [PW-1:0] w_next [NSLOT];
        int            w_count;
        int            w_nextCount;
        int            w_groups;

        w_aExt      = r_mode1 ? PW'($signed(r_a)) : PW'(r_a);
        w_bExt      = r_mode1 ? PW'($signed(r_b)) : PW'(r_b);
        w_count     = NPP;
        w_nextCount = 0;
        w_groups    = 0;
        for (int i = 0; i < NSLOT; i++) begin
            w_rows[i] = '0;
            w_next[i] = '0;
        end
        for (int i = 0; i < NPP; i++) begin
            w_rows[IW'(i)] = w_bExt[i] ? (w_aExt << i) : '0;
        end

        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            for (int i = 0; i < NSLOT; i++) begin
                w_next[i] = '0;
            end
            w_groups = w_count / 3;
            for (int g = 0; g < NPP / 3; g++) begin
                if (g < w_groups) begin
                    w_next[IW'(2*g)]   = w_rows[IW'(3*g)] ^ w_rows[IW'(3*g+1)] ^ w_rows[IW'(3*g+2)];
                    w_next[IW'(2*g+1)] = ((w_rows[IW'(3*g)]   & w_rows[IW'(3*g+1)]) |
                                          (w_rows[IW'(3*g)]   & w_rows[IW'(3*g+2)]) |
                                          (w_rows[IW'(3*g+1)] & w_rows[IW'(3*g+2)])) << 1;
                end
            end
            w_nextCount = 2 * w_groups;
            for (int i = 0; i < NPP; i++) begin
                if (i >= 3 * w_groups && i < w_count) begin
                    w_next[IW'(w_nextCount)] = w_rows[IW'(i)];
                    w_nextCount = w_nextCount + 1;
                end
            end
            w_rows  = w_next;
            w_count = w_nextCount;
        end

        w_product = w_rows[0] + w_rows[1];
    end

    // Stage 2: register the product; clear flag and mode travel alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2      <= 1'b0;
            r_product <= '0;
            r_clr2    <= 1'b0;
            r_mode2   <= 1'b0;
        end else begin
            r_v2      <= r_v1;
            r_product <= w_product;
            r_clr2    <= r_clr1;
            r_mode2   <= r_mode1;
        end
    end

    // Accumulate arithmetic: widen the product by the beat's mode, add with a
    // carry bit, and judge overflow in that same mode. When clamping, the
    // direction follows the accumulator sign, which equals the product sign
    // whenever a signed overflow is possible.
    always_comb begin
        w_extProd = r_mode2 ? ACC_WIDTH'($signed(r_product)) : ACC_WIDTH'(r_product);
        w_sum     = {1'b0, r_acc} + {1'b0, w_extProd};
        if (r_mode2) begin
            w_ovf    = (r_acc[ACC_WIDTH-1] == w_extProd[ACC_WIDTH-1]) &&
                       (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
            w_satVal = r_acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            w_ovf    = w_sum[ACC_WIDTH];
            w_satVal = '1;
        end
        if (r_clr2) begin
            w_accNext = w_extProd;
        end else if (w_ovf && SATURATE) begin
            w_accNext = w_satVal;
        end else begin
            w_accNext = w_sum[ACC_WIDTH-1:0];
        end
    end

    // Stage 3: update accumulator and sticky overflow on valid beats only;
    // bubbles leave both untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_outValid <= r_v2;
            if (r_v2) begin
                r_acc <= w_accNext;
                r_ovf <= r_clr2 ? 1'b0 : (r_ovf | w_ovf);
            end
        end
    end

    assign out_valid = r_outValid;
    assign acc_out   = r_acc;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_mac_unit.sv
// Testbench for pipelined_mac_unit. Three instances share one input stream:
// 40-bit wrapping, 32-bit clamping and 32-bit wrapping accumulators. An
// arithmetic reference model predicts each beat; predictions sit in a
// three-deep queue matching the pipeline latency.
module tb_pipelined_mac_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        clr = 1'b0;
    logic        signed_mode = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        outValid0, outValid1, outValid2;
    logic [39:0] accOut0;
    logic [31:0] accOut1, accOut2;
    logic        ovf0, ovf1, ovf2;

    typedef struct packed {
        logic        v;
        logic [2:0]  ovf;
        logic [63:0] acc0;
        logic [63:0] acc1;
        logic [63:0] acc2;
    } exp_t;

    exp_t        expQ[$];
    logic [63:0] modelAcc [3];
    logic        modelOvf [3];
    int          accBits  [3] = '{40, 32, 32};
    bit          accSat   [3] = '{1'b0, 1'b1, 1'b0};
    int          checkCount = 0;
    int          failCount  = 0;

    pipelined_mac_unit #(.WIDTH(16), .ACC_WIDTH(40), .SATURATE(1'b0)) u_mac40Wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
        .signed_mode(signed_mode), .out_valid(outValid0), .acc_out(accOut0), .overflow(ovf0));

    pipelined_mac_unit #(.WIDTH(16), .ACC_WIDTH(32), .SATURATE(1'b1)) u_mac32Sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
        .signed_mode(signed_mode), .out_valid(outValid1), .acc_out(accOut1), .overflow(ovf1));

    pipelined_mac_unit #(.WIDTH(16), .ACC_WIDTH(32), .SATURATE(1'b0)) u_mac32Wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
        .signed_mode(signed_mode), .out_valid(outValid2), .acc_out(accOut2), .overflow(ovf2));

    // Free-running clock.
    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: exact integer product and sum, then range test and wrap/clamp.
    function automatic void modelBeat(input int k, input bit c, input bit m,
                                      input logic [15:0] x, input logic [15:0] y);
        int          n;
        longint      prod, cur, sum, lo, hi, tmp;
        logic [63:0] msk;
        n   = accBits[k];
        msk = (64'd1 << n) - 64'd1;
        if (m) prod = longint'($signed(x)) * longint'($signed(y));
        else   prod = longint'({48'd0, x}) * longint'({48'd0, y});
        if (c) begin
            modelAcc[k] = 64'(prod) & msk;
            modelOvf[k] = 1'b0;
        end else begin
            if (m) begin
                tmp = longint'(modelAcc[k] << (64 - n));
                cur = tmp >>> (64 - n);
                lo  = -(longint'(1) << (n - 1));
                hi  = (longint'(1) << (n - 1)) - 1;
            end else begin
                cur = longint'(modelAcc[k]);
                lo  = 0;
                hi  = (longint'(1) << n) - 1;
            end
            sum = cur + prod;
            if (sum > hi || sum < lo) begin
                modelOvf[k] = 1'b1;
                if (accSat[k]) sum = (sum > hi) ? hi : lo;
            end
            modelAcc[k] = 64'(sum) & msk;
        end
    endfunction

    function automatic exp_t snapshot(input logic v);
        exp_t e;
        e.v    = v;
        e.ovf  = {modelOvf[2], modelOvf[1], modelOvf[0]};
        e.acc0 = modelAcc[0];
        e.acc1 = modelAcc[1];
        e.acc2 = modelAcc[2];
        return e;
    endfunction

    task automatic compareEntry(input exp_t e);
        checkOutput("outValid40w", 64'(outValid0), 64'(e.v));
        checkOutput("outValid32s", 64'(outValid1), 64'(e.v));
        checkOutput("outValid32w", 64'(outValid2), 64'(e.v));
        checkOutput("acc40w",      64'(accOut0),   e.acc0);
        checkOutput("acc32s",      64'(accOut1),   e.acc1);
        checkOutput("acc32w",      64'(accOut2),   e.acc2);
        checkOutput("ovf40w",      64'(ovf0),      64'(e.ovf[0]));
        checkOutput("ovf32s",      64'(ovf1),      64'(e.ovf[1]));
        checkOutput("ovf32w",      64'(ovf2),      64'(e.ovf[2]));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Valid"}, 64'({outValid2, outValid1, outValid0}), 64'd0);
        checkOutput({tag, "Acc40"}, 64'(accOut0), 64'd0);
        checkOutput({tag, "Acc32"}, 64'({accOut1, accOut2}), 64'd0);
        checkOutput({tag, "Ovf"},   64'({ovf2, ovf1, ovf0}), 64'd0);
    endtask

    // One clock of stimulus: check the beat now due at the outputs, advance
    // the model, and drive the next beat.
    task automatic applyStimulus(input bit v, input bit c, input bit m,
                                 input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        if (expQ.size() == 3) compareEntry(expQ.pop_front());
        if (v) begin
            for (int k = 0; k < 3; k++) modelBeat(k, c, m, x, y);
        end
        expQ.push_back(snapshot(v));
        in_valid    = v;
        clr         = c;
        signed_mode = m;
        a           = x;
        b           = y;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    // Asserts reset between edges, checks outputs clear at once and stay clear.
    task automatic applyReset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        checkResetState("rstAssert");
        repeat (2) begin
            @(negedge clk);
            checkResetState("rstHold");
        end
        @(negedge clk);
        checkResetState("rstRelease");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            modelAcc[k] = 64'd0;
            modelOvf[k] = 1'b0;
        end
        expQ.delete();
        repeat (3) expQ.push_back(snapshot(1'b0));
    endtask

    function automatic logic [15:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 16'hFFFF;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Directed scenarios with known results, then a randomized run.
    initial begin
        bit          rv, rc, rm;
        logic [15:0] rx, ry;

        applyReset();

        applyStimulus(1'b1, 1'b1, 1'b0, 16'd123, 16'd456);
        idle(3);
        checkOutput("single40", 64'(accOut0), 64'd56088);
        checkOutput("singleOvf", 64'(ovf0), 64'd0);

        applyStimulus(1'b1, 1'b1, 1'b0, 16'd1, 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd255, 16'd255);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd65535, 16'd65535);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd500, 16'd1000);
        idle(3);
        checkOutput("burst40", 64'(accOut0), 64'd4295401251);
        checkOutput("burstOvf", 64'(ovf0), 64'd0);

        applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFE, 16'd3);
        idle(3);
        checkOutput("signedNeg6", 64'(accOut0), 64'hFF_FFFF_FFFA);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h8000, 16'h8000);
        idle(3);
        checkOutput("signedMin2", 64'(accOut0), 64'd1073741818);

        applyStimulus(1'b1, 1'b1, 1'b0, 16'd65535, 16'd65535);
        idle(3);
        checkOutput("sat32Start", 64'(accOut1), 64'd4294836225);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd65535, 16'd2);
        idle(3);
        checkOutput("sat32Full", 64'(accOut1), 64'hFFFF_FFFF);
        checkOutput("sat32FullOvf", 64'(ovf1), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd1, 16'd1);
        idle(3);
        checkOutput("sat32Clamp", 64'(accOut1), 64'hFFFF_FFFF);
        checkOutput("sat32ClampOvf", 64'(ovf1), 64'd1);
        checkOutput("wrap32Zero", 64'(accOut2), 64'd0);
        checkOutput("wrap32ZeroOvf", 64'(ovf2), 64'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd2, 16'd3);
        idle(3);
        checkOutput("sat32Clr", 64'(accOut1), 64'd6);
        checkOutput("sat32ClrOvf", 64'(ovf1), 64'd0);
        checkOutput("wrap32ClrOvf", 64'(ovf2), 64'd0);

        applyStimulus(1'b1, 1'b1, 1'b0, 16'd7, 16'd9);
        idle(5);
        checkOutput("bubbleHold", 64'(accOut0), 64'd63);

        applyStimulus(1'b1, 1'b0, 1'b0, 16'd1000, 16'd1000);
        applyReset();
        idle(4);
        checkOutput("postResetAcc", 64'(accOut0), 64'd0);
        checkOutput("postResetOvf", 64'(ovf0), 64'd0);

        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 7) == 0);
            rm = $urandom_range(0, 1) != 0;
            rx = pickOperand();
            ry = pickOperand();
            if (i == 200) applyReset();
            applyStimulus(rv, rc, rm, rx, ry);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
